// File: rtl/logic_reduce_unit.sv
// Folds COUNT operands with AND/OR/XOR/NOR over a ready/valid input stream and presents one registered result.
// Optional ZERO flag output is enabled by defining LOGIC_REDUCE_ZERO_FLAG_EN.
module logic_reduce_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OPSEL,
  input  logic [CNT_W-1:0] COUNT,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY
`ifdef LOGIC_REDUCE_ZERO_FLAG_EN
  ,
  output logic             ZERO
`endif
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
`ifdef LOGIC_REDUCE_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          op_d    = OPSEL;
          rem_d   = COUNT;
          acc_d   = (OPSEL == OP_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
          state_d = (COUNT == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (IN_VALID) begin
          case (op_q)
            OP_AND:  acc_d = acc_q & DATA;
            OP_XOR:  acc_d = acc_q ^ DATA;
            default: acc_d = acc_q | DATA;
          endcase
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result is computed from next state so it is registered and visible the cycle DONE is entered.
  always_comb begin
    out_valid_d = (state_d == DONE);
    result_d    = {WIDTH{1'b0}};
    if (out_valid_d) result_d = (op_d == OP_NOR) ? ~acc_d : acc_d;
  end

`ifdef LOGIC_REDUCE_ZERO_FLAG_EN
  always_comb begin
    zero_d = out_valid_d && (result_d == {WIDTH{1'b0}});
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
`ifdef LOGIC_REDUCE_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
`ifdef LOGIC_REDUCE_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign IN_READY  = (state_q == ACCUM);
  assign BUSY      = (state_q != IDLE);
  assign OUT_VALID = out_valid_q;
  assign RESULT    = result_q;
`ifdef LOGIC_REDUCE_ZERO_FLAG_EN
  assign ZERO      = zero_q;
`endif

endmodule
